// File: rtl/timebase_ctrl.sv
// timebase_ctrl: divide-by-N timebase with square wave, tick pulse, tick count and handshaked run-time half-period reconfig
module timebase_ctrl #(
  parameter int          CNT_W        = 27,
  parameter int unsigned DEFAULT_HALF = 25_000_000
) (
  input  logic             clk_50mHz,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             clk_out,
  output logic             tick,
  output logic [7:0]       tick_cnt,
  output logic             running
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  state_t           state;
  logic [CNT_W-1:0] cnt, half_reg, pend_half, new_half;
  logic             pend_vld, acc, last, boundary;
  assign new_half  = (cfg_half == '0) ? CNT_W'(1) : cfg_half;
  assign acc       = cfg_valid && !pend_vld;
  assign last      = cnt == half_reg - CNT_W'(1);
  assign boundary  = last && state == LOW;
  assign cfg_ready = !pend_vld;
  always_ff @(posedge clk_50mHz) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      half_reg  <= CNT_W'(DEFAULT_HALF);
      pend_half <= '0;
      pend_vld  <= 1'b0;
      clk_out   <= 1'b0;
      tick      <= 1'b0;
      tick_cnt  <= '0;
      running   <= 1'b0;
    end else if (!en || state == IDLE) begin
      state    <= en ? HIGH : IDLE;
      cnt      <= '0;
      pend_vld <= 1'b0;
      half_reg <= acc ? new_half : pend_vld ? pend_half : half_reg;
      clk_out  <= en;
      tick     <= en;
      running  <= en;
      tick_cnt <= en ? tick_cnt + 8'd1 : tick_cnt;
    end else begin
      cnt      <= last ? '0 : cnt + CNT_W'(1);
      state    <= last ? (state == HIGH ? LOW : HIGH) : state;
      clk_out  <= (state == HIGH) != last;
      tick     <= boundary;
      tick_cnt <= boundary ? tick_cnt + 8'd1 : tick_cnt;
      if (boundary && pend_vld) begin
        half_reg <= pend_half;
        pend_vld <= 1'b0;
      end
      if (acc) begin
        pend_half <= new_half;
        pend_vld  <= 1'b1;
      end
    end
  end
endmodule
